// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer driving the data-RAM port. Aligned accesses use one memory
// beat; misaligned halfword/word accesses are split into byte beats and reassembled.
module lsu_mem_ctrl (
  input  logic        sclk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [2:0]  mem_op,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_CAP, S_ERR, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] asm_q, asm_d;
  logic        cap_wr_q, cap_wr_d;
  logic        cap_mis_q, cap_mis_d;
  logic [2:0]  cap_op_q, cap_op_d;
  logic [31:0] cap_addr_q, cap_addr_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_rd_q, mem_rd_d;
  logic [2:0]  mem_op_q, mem_op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;
  logic        last_beat;

  function automatic logic op_supported(input logic wr, input logic [2:0] op);
    if (wr) return (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
           (op == 3'b100) || (op == 3'b101);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [31:0] a);
    case (op[1:0])
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] final_beat(input logic [2:0] op, input logic mis);
    if (!mis) return 2'd0;
    return (op[1:0] == 2'b01) ? 2'd1 : 2'd3;
  endfunction

  // Aligned halfwords arrive pre-extended, so re-extending them is a no-op.
  function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b101:  return {16'h0000, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign accept    = req_valid && req_ready_q;
  assign last_beat = (beat_q == final_beat(cap_op_q, cap_mis_q));

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    asm_d       = asm_q;
    cap_wr_d    = cap_wr_q;
    cap_mis_d   = cap_mis_q;
    cap_op_d    = cap_op_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cap_wr_d    = req_wr;
          cap_op_d    = req_op;
          cap_addr_d  = req_addr;
          cap_wdata_d = req_wdata;
          cap_mis_d   = misaligned(req_op, req_addr);
          beat_d      = 2'd0;
          asm_d       = 32'h0;
          state_d     = op_supported(req_wr, req_op) ? S_ACC : S_ERR;
        end
      end
      S_ACC: begin
        if (!cap_wr_q)      state_d = S_CAP;
        else if (last_beat) state_d = S_RESP;
        else                beat_d  = beat_q + 2'd1;
      end
      S_CAP: begin
        if (cap_mis_q) asm_d[{beat_q, 3'b000} +: 8] = rdata[7:0];
        else           asm_d = rdata;
        if (last_beat) begin
          state_d = S_RESP;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = S_ACC;
        end
      end
      S_ERR:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so strobes land one cycle after the decision.
  always_comb begin
    mem_wr_d = 1'b0;
    mem_rd_d = 1'b0;
    mem_op_d = 3'b000;
    addr_d   = 32'h0;
    wdata_d  = 32'h0;
    if (state_d == S_ACC) begin
      mem_wr_d = cap_wr_d;
      mem_rd_d = !cap_wr_d;
      if (cap_mis_d) begin
        mem_op_d = cap_wr_d ? OP_SB : OP_LBU;
        addr_d   = cap_addr_d + {30'h0, beat_d};
        wdata_d  = cap_wr_d ? {24'h0, cap_wdata_d[{beat_d, 3'b000} +: 8]} : 32'h0;
      end else begin
        mem_op_d = cap_op_d;
        addr_d   = cap_addr_d;
        wdata_d  = cap_wr_d ? cap_wdata_d : 32'h0;
      end
    end
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_err_d   = resp_valid_d && (state_q == S_ERR);
    resp_rdata_d = (resp_valid_d && (state_q == S_CAP)) ? extend_load(cap_op_q, asm_d) : 32'h0;
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      beat_q       <= 2'd0;
      asm_q        <= 32'h0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_op_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      asm_q        <= asm_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
      mem_op_q     <= mem_op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Captured request fields are only consumed outside IDLE, so they need no reset.
  always_ff @(posedge sclk) begin
    cap_wr_q    <= cap_wr_d;
    cap_mis_q   <= cap_mis_d;
    cap_op_q    <= cap_op_d;
    cap_addr_q  <= cap_addr_d;
    cap_wdata_q <= cap_wdata_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_wr     = mem_wr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_op     = mem_op_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store sequencer on the CPU side of the data-memory port; it is the initiator that drives the data-RAM wrapper's `mem_wr`/`mem_rd`/`mem_op`/`addr`/`wdata` and consumes its `rdata`. It accepts one load/store request at a time from the execute stage. Aligned accesses go out as a single memory operation. Misaligned halfword/word accesses become a sequence of byte accesses, with the results reassembled and sign-/zero-extended. The block returns a one-cycle response pulse carrying load data or a store acknowledge.

## Interface
- No parameters; data and address are fixed at 32 bits, and the memory read latency is fixed at 1 cycle.
- `sclk` input 1: system clock; all state changes on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept; high only in IDLE.
- `req_wr` input 1: 1 = store, 0 = load.
- `req_op` input 3: RISC-V funct3; loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: unsupported `req_op`; valid with `resp_valid`.
- `mem_wr`, `mem_rd` output 1 each: memory strobes; the two are never high together.
- `mem_op` output 3, `addr` output 32, `wdata` output 32: memory command.
- `rdata` input 32: memory read data, valid the cycle after `mem_rd`.

## Operation
- Handshake: a request is accepted when `req_valid && req_ready`. Request fields are captured into registers at that point; the inputs are ignored afterwards until the block returns to IDLE.
- Alignment rules:
  - Byte ops are always aligned.
  - Half ops are aligned iff `addr[0]==0`.
  - Word ops are aligned iff `addr[1:0]==00`.
- Unsupported op: loads with 011/110/111, or stores with op other than 000/001/010.
  - No memory strobe is issued.
  - Block goes to RESP with `resp_err=1` and `resp_rdata=0`.
- Aligned access, one beat:
  - `mem_op` = captured op and `addr` = captured address.
  - Store: `wdata` = `req_wdata` unchanged; the memory does lane placement.
  - Load: the memory returns already-extended data, which the block registers directly.
- Misaligned access, N beats: N=2 for half, N=4 for word. Beat i (i=0..N-1) uses:
  - `addr` = base+i, modulo 2^32 (wraps from 0xFFFFFFFF to 0x00000000).
  - Store beat: `mem_op`=000 (SB), `wdata[7:0]` = store byte i, `wdata[31:8]`=0.
  - Load beat: `mem_op`=100 (LBU); the captured `rdata[7:0]` is written to assembly byte i.
- Final extension of assembled load data:
  - LH: bits 31:16 = bit 15.
  - LHU: bits 31:16 = 0.
  - LW: no extension.
- FSM states:
  - IDLE → ERR on accept with unsupported op; → ACC on accept otherwise.
  - ACC: assert `mem_wr` or `mem_rd` for exactly one cycle. Store → next beat's ACC if beats remain, else RESP. Load → CAP.
  - CAP: register `rdata`. → ACC if beats remain, else RESP.
  - ERR: one cycle, → RESP.
  - RESP: `resp_valid=1` for one cycle, → IDLE.
- A beat counter (2 bits) selects the byte and address offset for each beat.
- Memory outputs are registered. When no strobe is asserted, `mem_op`, `addr` and `wdata` are 0.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_wr=0`, `mem_rd=0`, `mem_op=0`, `addr=0`, `wdata=0`. FSM goes to IDLE; counter and assembly register clear. `req_ready` rises in the first cycle after reset release.
- Latency, with accept at cycle T:
  - Aligned store: `mem_wr` at T+1; `resp_valid` at T+2.
  - Aligned load: `mem_rd` at T+1; capture at T+2; `resp_valid` at T+3.
  - Misaligned store: strobes at T+1..T+N; `resp_valid` at T+N+1.
  - Misaligned load: strobes at T+1, T+3, …, T+2N−1; `resp_valid` at T+2N+1.
  - Unsupported op: ERR at T+1; `resp_valid` at T+2.
- `req_ready` is low from T+1 through the RESP cycle. It is high again in the cycle after RESP, so back-to-back throughput is one request per latency+1 cycles.
- `resp_rdata` and `resp_err` are valid only while `resp_valid=1`. They return to 0 afterwards.
- Reset asserted mid-operation: all outputs go to reset values immediately. The current beat is abandoned, no response is issued, and no further strobes occur.

## Test plan
- Aligned LW at 0x100 → `mem_rd`=1 with `addr`=0x100 and `mem_op`=010 at T+1. With `rdata`=0xDEADBEEF at T+2 → `resp_valid` at T+3, `resp_rdata`=0xDEADBEEF.
- Misaligned SW at 0x203 with `wdata`=0x11223344 → four SB strobes at T+1..T+4, at addresses 0x203, 0x204, 0x205, 0x206 with `wdata` 0x44, 0x33, 0x22, 0x11. `resp_valid` at T+5.
- Misaligned LH at 0x101 with bytes returned 0x80 then 0xFF → two LBU reads at 0x101 and 0x102. `resp_rdata`=0xFFFFFF80 at T+5. The same sequence as LHU → 0x0000FF80.
- Misaligned LW at 0xFFFFFFFE → beat addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001. Response at T+9.
- Load with op 011 → no strobe; `resp_valid` at T+2 with `resp_err`=1 and `resp_rdata`=0. `req_ready` is low during T+1..T+2.
- `rstn` low at T+2 of a misaligned SW → all outputs 0 immediately and no `resp_valid`. After release, an SB at 0x10 completes normally.
